// File: rtl/pkt_out_filter.sv
// Egress packet filter: forwards or discards whole packets by a tuser drop bit,
// 2-entry output skid buffer, optional packet counters (PKT_OUT_FILTER_STATS_EN).
//
// Ports:
//   axis_clk, aresetn        clock, async active-low reset
//   s_axis_*                 ingress AXI-Stream (tdata/tkeep/tuser/tlast/tvalid/tready)
//   m_axis_*                 egress AXI-Stream, driven from the skid head register
//   stat_clear               synchronous counter clear (ignored without the macro)
//   stat_fwd_pkts            forwarded packet count (saturating, 0 without the macro)
//   stat_drop_pkts           dropped packet count (saturating, 0 without the macro)
module pkt_out_filter #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_DROP_BIT         = 127
) (
   input  logic                            axis_clk,
   input  logic                            aresetn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   input  logic                            m_axis_tready,
   input  logic                            stat_clear,
   output logic [31:0]                     stat_fwd_pkts,
   output logic [31:0]                     stat_drop_pkts
);

   localparam int KW = C_AXIS_DATA_WIDTH / 8;

   typedef struct packed {
      logic [C_AXIS_DATA_WIDTH-1:0]  data;
      logic [KW-1:0]                 keep;
      logic [C_AXIS_TUSER_WIDTH-1:0] user;
      logic                          last;
   } beat_t;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_FWD   = 2'd1,
      ST_DROP  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] occ_q, occ_d;
   beat_t      head_q, head_d;
   beat_t      tail_q, tail_d;
   beat_t      in_beat;

   logic       s_rdy;
   logic       acc;
   logic       drop_bit;
   logic       fwd_beat;
   logic       push;
   logic       pop;
   logic       first_acc;

   assign in_beat = '{data: s_axis_tdata,
                      keep: s_axis_tkeep,
                      user: s_axis_tuser,
                      last: s_axis_tlast};

   assign drop_bit = s_axis_tuser[C_DROP_BIT];

   // Ready depends only on state, occupancy and reset, never on beat contents.
   assign s_rdy = aresetn &
                  ((state_q == ST_DROP) | (occ_q != 2'd2));

   assign acc       = s_axis_tvalid & s_rdy;
   assign first_acc = acc & (state_q == ST_FIRST);
   assign pop       = m_axis_tvalid & m_axis_tready;

   always_comb begin
      fwd_beat = 1'b0;
      unique case (state_q)
         ST_FIRST: fwd_beat = ~drop_bit;
         ST_FWD:   fwd_beat = 1'b1;
         ST_DROP:  fwd_beat = 1'b0;
         default:  fwd_beat = 1'b0;
      endcase
   end

   assign push = acc & fwd_beat;

   // Packet framing FSM
   always_comb begin
      state_d = state_q;
      if (acc) begin
         unique case (state_q)
            ST_FIRST: begin
               if (!s_axis_tlast)
                  state_d = drop_bit ? ST_DROP : ST_FWD;
            end
            ST_FWD, ST_DROP: begin
               if (s_axis_tlast)
                  state_d = ST_FIRST;
            end
            default: state_d = ST_FIRST;
         endcase
      end
   end

   // Skid buffer: head drives m_axis, tail only fills when head is stalled.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      unique case (occ_q)
         2'd0: begin
            if (push) begin
               head_d = in_beat;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_beat;
            end else if (push) begin
               tail_d = in_beat;
               occ_d  = 2'd2;
            end else if (pop) begin
               occ_d  = 2'd0;
            end
         end
         2'd2: begin
            // push cannot happen here: ready is low in FIRST/FWD
            if (pop) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end
         end
         default: occ_d = 2'd0;
      endcase
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_FIRST;
         occ_q   <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign s_axis_tready = s_rdy;
   assign m_axis_tvalid = (occ_q != 2'd0);
   assign m_axis_tdata  = head_q.data;
   assign m_axis_tkeep  = head_q.keep;
   assign m_axis_tuser  = head_q.user;
   assign m_axis_tlast  = head_q.last;

`ifdef PKT_OUT_FILTER_STATS_EN
   logic [31:0] fwd_cnt_q, fwd_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   // Clear has priority over a coincident increment; counts saturate.
   always_comb begin
      fwd_cnt_d  = fwd_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (stat_clear) begin
         fwd_cnt_d  = '0;
         drop_cnt_d = '0;
      end else if (first_acc) begin
         if (!drop_bit && fwd_cnt_q != 32'hFFFF_FFFF)
            fwd_cnt_d = fwd_cnt_q + 32'd1;
         if (drop_bit && drop_cnt_q != 32'hFFFF_FFFF)
            drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         fwd_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         fwd_cnt_q  <= fwd_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign stat_fwd_pkts  = fwd_cnt_q;
   assign stat_drop_pkts = drop_cnt_q;
`else
   logic unused_stat;
   assign unused_stat    = stat_clear ^ first_acc;
   assign stat_fwd_pkts  = '0;
   assign stat_drop_pkts = '0;
`endif

endmodule

// File: tb/tb_pkt_out_filter.sv
// Scoreboard bench for pkt_out_filter: packet-level reference model feeds an
// expected-beat queue, a negedge monitor pops and compares egress beats.
module tb_pkt_out_filter;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int KW = DW / 8;
   localparam int DB = 127;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic [UW-1:0] s_tuser;
   logic          s_valid;
   logic          s_tlast;
   logic          s_ready;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [UW-1:0] m_tuser;
   logic          m_valid;
   logic          m_tlast;
   logic          m_ready;
   logic          stat_clear;
   logic [31:0]   stat_fwd;
   logic [31:0]   stat_drop;

   logic          rnd_ready;
   logic          force_ready;

   int            n_chk;
   int            n_fail;

   beat_t         exp_q[$];
   bit            in_pkt;
   bit            cur_drop;
   longint        exp_fwd;
   longint        exp_drop;

   pkt_out_filter dut (
      .axis_clk      (clk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_valid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_ready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_valid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_ready),
      .stat_clear    (stat_clear),
      .stat_fwd_pkts (stat_fwd),
      .stat_drop_pkts(stat_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;
   end

   task automatic chk(input bit ok, input string name,
                      input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input longint v);
`ifdef PKT_OUT_FILTER_STATS_EN
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
      return (v < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   // Reference model: whole packets classified by first-beat drop bit.
   always @(negedge clk) begin
      if (!aresetn) begin
         exp_q.delete();
         in_pkt   = 1'b0;
         cur_drop = 1'b0;
         exp_fwd  = 0;
         exp_drop = 0;
         chk(m_valid === 1'b0, "rst_mvalid", DW'(m_valid), 0);
         chk(s_ready === 1'b0, "rst_sready", DW'(s_ready), 0);
         chk(m_tdata === '0, "rst_mdata", m_tdata, 0);
         chk(stat_fwd === 32'd0, "rst_fwd", DW'(stat_fwd), 0);
      end else begin
         chk(stat_fwd === exp_cnt(exp_fwd), "stat_fwd",
             DW'(stat_fwd), DW'(exp_cnt(exp_fwd)));
         chk(stat_drop === exp_cnt(exp_drop), "stat_drop",
             DW'(stat_drop), DW'(exp_cnt(exp_drop)));
         if (s_valid && s_ready) begin
            if (!in_pkt) begin
               cur_drop = s_tuser[DB];
               if (cur_drop) exp_drop++;
               else          exp_fwd++;
            end
            if (!cur_drop)
               exp_q.push_back('{d: s_tdata, k: s_tkeep,
                                 u: s_tuser, l: s_tlast});
            in_pkt = !s_tlast;
         end
         if (stat_clear) begin
            exp_fwd  = 0;
            exp_drop = 0;
         end
      end
   end

   // Egress monitor with hold-stability check.
   beat_t held;
   bit    hold;
   always @(negedge clk) begin
      beat_t e;
      if (!aresetn) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk(m_valid === 1'b1, "hold_valid", DW'(m_valid), 1);
            chk(m_tdata === held.d && m_tkeep === held.k &&
                m_tuser === held.u && m_tlast === held.l,
                "hold_stable", m_tdata, held.d);
         end
         if (m_valid && m_ready) begin
            hold = 1'b0;
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_beat", m_tdata, 0);
            end else begin
               e = exp_q.pop_front();
               chk(m_tdata === e.d, "out_data", m_tdata, e.d);
               chk(m_tkeep === e.k, "out_keep", DW'(m_tkeep), DW'(e.k));
               chk(m_tuser === e.u, "out_user", DW'(m_tuser), DW'(e.u));
               chk(m_tlast === e.l, "out_last", DW'(m_tlast), DW'(e.l));
            end
         end else if (m_valid) begin
            hold = 1'b1;
            held = '{d: m_tdata, k: m_tkeep, u: m_tuser, l: m_tlast};
         end else begin
            hold = 1'b0;
         end
      end
   end

   function automatic beat_t mk_beat(input bit drop, input bit last);
      beat_t b;
      for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
      b.k = $urandom;
      for (int i = 0; i < UW / 32; i++) b.u[i*32 +: 32] = $urandom;
      b.u[DB] = drop;
      b.l = last;
      return b;
   endfunction

   task automatic drive(input beat_t b);
      s_tdata = b.d;
      s_tkeep = b.k;
      s_tuser = b.u;
      s_tlast = b.l;
      s_valid = 1'b1;
   endtask

   task automatic send_beat(input beat_t b, output int waits);
      drive(b);
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!s_ready && waits < 2000);
      if (!s_ready) chk(1'b0, "send_timeout", DW'(waits), 0);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      @(negedge clk);
      chk(exp_q.size() == 0, "drain_empty", DW'(exp_q.size()), 0);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b;
      beat_t pkt[4];
      int    w;
      int    len;
      bit    drp;
      n_chk       = 0;
      n_fail      = 0;
      rnd_ready   = 1'b0;
      force_ready = 1'b1;
      aresetn     = 1'b0;
      s_valid     = 1'b0;
      s_tlast     = 1'b0;
      s_tdata     = '0;
      s_tkeep     = '0;
      s_tuser     = '0;
      stat_clear  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      aresetn = 1'b1;
      #1;
      chk(s_ready === 1'b1, "ready_after_rst", DW'(s_ready), 1);
      wait_cycles(1);

      // 3-beat forward packet, one cycle latency
      for (int i = 0; i < 3; i++) begin
         b = mk_beat(1'b0, i == 2);
         send_beat(b, w);
         chk(m_valid === 1'b1 && m_tdata === b.d, "latency",
             m_tdata, b.d);
      end
      drain();

      // 2-beat drop packet then 1-beat forward packet
      for (int i = 0; i < 2; i++) begin
         b = mk_beat(i == 0, i == 1);
         send_beat(b, w);
         chk(w == 1, "drop_ready", DW'(w), 1);
      end
      b = mk_beat(1'b0, 1'b1);
      send_beat(b, w);
      drain();

      // Backpressure: 4-beat packet with egress stalled
      force_ready = 1'b0;
      wait_cycles(2);
      for (int i = 0; i < 4; i++) pkt[i] = mk_beat(1'b0, i == 3);
      send_beat(pkt[0], w);
      send_beat(pkt[1], w);
      drive(pkt[2]);
      repeat (3) begin
         @(negedge clk);
         chk(s_ready === 1'b0, "full_not_ready", DW'(s_ready), 0);
      end
      force_ready = 1'b1;
      send_beat(pkt[2], w);
      send_beat(pkt[3], w);
      drain();

      // stat_clear coincident with a forward first beat
      stat_clear = 1'b1;
      b = mk_beat(1'b0, 1'b1);
      send_beat(b, w);
      stat_clear = 1'b0;
      @(negedge clk);
      chk(stat_fwd === 32'd0, "clear_wins", DW'(stat_fwd), 0);
      drain();

      // Reset mid-packet with one beat buffered
      force_ready = 1'b0;
      wait_cycles(2);
      b = mk_beat(1'b0, 1'b0);
      send_beat(b, w);
      aresetn = 1'b0;
      #1;
      chk(m_valid === 1'b0, "rst_immediate", DW'(m_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      aresetn     = 1'b1;
      force_ready = 1'b1;
      b = mk_beat(1'b1, 1'b1);
      send_beat(b, w);
      b = mk_beat(1'b0, 1'b1);
      send_beat(b, w);
      drain();

      // Random traffic, 50% egress ready
      rnd_ready = 1'b1;
      for (int p = 0; p < 100; p++) begin
         len = $urandom_range(1, 4);
         drp = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < len; i++) begin
            b = mk_beat(drp, i == len - 1);
            if (i > 0) b.u[DB] = $urandom_range(0, 1);
            stat_clear = (i == 0) && ($urandom_range(0, 19) == 0);
            send_beat(b, w);
            stat_clear = 1'b0;
            if ($urandom_range(0, 3) == 0) wait_cycles(1);
         end
      end
      drain();
      rnd_ready = 1'b0;
      wait_cycles(2);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/pkt_out_filter.md
PKT_OUT_FILTER -- requirements
Module: pkt_out_filter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: data width in bits.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width in bits.
REQ-003 SHALL have parameter C_DROP_BIT, default 127: tuser bit index that marks a packet for discard.
REQ-004 SHALL have port axis_clk, input, 1: single clock for the block; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port s_axis_tdata, input, C_AXIS_DATA_WIDTH: beat data from the deparser output.
REQ-007 SHALL have port s_axis_tkeep, input, C_AXIS_DATA_WIDTH/8: byte enables.
REQ-008 SHALL have port s_axis_tuser, input, C_AXIS_TUSER_WIDTH: metadata, meaningful on the first beat only.
REQ-009 SHALL have ports s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1): slave handshake.
REQ-010 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid and m_axis_tlast (outputs, widths as s_axis) and m_axis_tready (input, 1): egress stream.
REQ-011 SHALL have port stat_clear, input, 1: synchronous clear of the counters.
REQ-012 SHALL have ports stat_fwd_pkts and stat_drop_pkts, outputs, 32 each: packet counters.

Function
REQ-013 SHALL implement FSM states FIRST, FWD and DROP, with reset state FIRST.
REQ-014 In FIRST, an accepted beat SHALL be classified as drop when s_axis_tuser[C_DROP_BIT]=1 and as forward otherwise.
REQ-015 FIRST SHALL transition to FWD on an accepted forward beat with tlast=0, to DROP on an accepted drop beat with tlast=0, and stay in FIRST when the accepted beat has tlast=1.
REQ-016 FWD and DROP SHALL return to FIRST on an accepted beat with tlast=1 and otherwise hold.
REQ-017 Forwarded beats SHALL be written, unmodified (data, keep, user, last), into a 2-entry output skid buffer.
REQ-018 Dropped beats SHALL be consumed and discarded, and SHALL NOT appear on m_axis.
REQ-019 s_axis_tready SHALL be 1 in DROP; in FIRST and FWD it SHALL be 1 iff skid occupancy < 2.
REQ-020 s_axis_tready SHALL NOT depend combinationally on s_axis_tdata or s_axis_tuser.
REQ-021 m_axis outputs SHALL be driven from the skid head register.
REQ-022 Latency: a forward beat accepted in cycle N SHALL be visible on m_axis in cycle N+1 when the buffer was empty.
REQ-023 Beat ordering SHALL be preserved with no duplication or loss under arbitrary m_axis_tready patterns.
REQ-024 m_axis_tvalid SHALL stay asserted, and m_axis_* stable, until m_axis_tready=1.
REQ-025 A simultaneous push and pop at occupancy 2 SHALL be impossible, because tready=0 at occupancy 2; at occupancy 1, a simultaneous push and pop SHALL keep occupancy at 1.
REQ-026 stat_fwd_pkts SHALL increment once per accepted forward first beat; stat_drop_pkts SHALL increment once per accepted drop first beat.
REQ-027 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-028 When stat_clear coincides with an increment, stat_clear SHALL win and the counter SHALL read 0 next cycle.

Reset
REQ-029 While aresetn=0: FSM=FIRST, skid occupancy=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, s_axis_tready=0, counters=0.
REQ-030 On the first cycle after deassertion, s_axis_tready SHALL be 1.
REQ-031 Reset mid-packet SHALL discard buffered beats, and the next accepted beat SHALL be treated as a first beat.

Configuration
REQ-032 With macro PKT_OUT_FILTER_STATS_EN defined, the counters SHALL be implemented as specified above.
REQ-033 Without PKT_OUT_FILTER_STATS_EN, stat_fwd_pkts and stat_drop_pkts SHALL be tied to 0, no counter registers SHALL be inferred, stat_clear SHALL be ignored, and datapath behaviour SHALL be identical.

Verification
REQ-034 3-beat packet with tuser[127]=0 and m_axis_tready=1 -> 3 beats out, each one cycle after acceptance, identical content; stat_fwd_pkts=1.
REQ-035 2-beat packet with tuser[127]=1, followed by a 1-beat forward packet -> only the 1-beat packet is emitted; stat_drop_pkts=1 and stat_fwd_pkts=1; s_axis_tready=1 throughout the dropped beats.
REQ-036 m_axis_tready held 0 while a 4-beat forward packet is offered -> exactly 2 beats accepted, then s_axis_tready=0; on release, all 4 beats are emitted in order with none lost.
REQ-037 Random m_axis_tready (50%) with 100 mixed packets -> output equals the input stream with drop-marked packets removed; counters match the reference model.
REQ-038 aresetn pulsed low mid-packet with 1 beat buffered -> m_axis_tvalid=0 immediately; after release, the next beat is classified from its own tuser.
REQ-039 stat_clear=1 in the same cycle as a forward first beat -> stat_fwd_pkts=0 next cycle; with the macro undefined, both counters remain 0 throughout.
